bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the BCD-to-seven-segment decoder in the frequency counter. It accepts the binary count latched at the end of each gate window and produces packed BCD digits, one 4-bit nibble per display digit, for the decoders. Its output register holds the previous result for the whole conversion, so the display never shows intermediate values.

---
 rtl/freq_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 102 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency counter display path.
package freq_pkg;

    // Converter sequencing states
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Width of one BCD digit
    localparam int unsigned DIGIT_W = 4;

    // Digits at or above this value get +3 before each shift
    localparam int unsigned ADD3_THRESH = 5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction: if the digit is 5 or more, add 3.
module bcd_digit_adj
    import freq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    // Pre-shift correction so the doubled digit carries correctly into the next one
    always_comb begin
        adjusted = digit;
        if (digit >= DIGIT_W'(ADD3_THRESH)) begin
            adjusted = digit + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// Output registers only change when a conversion completes, so the display
// never sees intermediate values.
module bin_to_bcd_seq
    import freq_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 20,
    parameter int unsigned DIGITS    = 7
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Start,
    input  logic [BIN_WIDTH-1:0]   Bin,
    output logic                   Busy,
    output logic                   Done,
    output logic [4*DIGITS-1:0]    BCD,
    output logic                   Overflow
);

    localparam int unsigned CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e               state_q;
    logic [BIN_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]     work_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_q;

    logic [BCD_W-1:0]     work_adj;
    logic [BCD_W-1:0]     work_next;
    logic                 ovf_next;

    // Per-digit add-3 correction applied to the working register
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (work_q[DIGIT_W*i +: DIGIT_W]),
            .adjusted (work_adj[DIGIT_W*i +: DIGIT_W])
        );
    end

    // Corrected digits shift left, taking the next binary bit MSB-first; the bit
    // leaving the top digit means the value no longer fits in DIGITS digits
    always_comb begin
        work_next = {work_adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
        ovf_next  = ovf_q | work_adj[BCD_W-1];
    end

    // Conversion FSM with datapath and registered outputs
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            BCD      <= '0;
            Overflow <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        shift_q <= Bin;
                        work_q  <= '0;
                        cnt_q   <= CNT_LOAD;
                        ovf_q   <= 1'b0;
                        Busy    <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q  <= work_next;
                    shift_q <= shift_q << 1;
                    ovf_q   <= ovf_next;
                    cnt_q   <= cnt_q - CNT_ONE;
                    if (cnt_q == '0) begin
                        // Final shift: load the outputs now so they are visible
                        // for the whole DONE cycle together with the Done pulse
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        BCD      <= work_next;
                        Overflow <= ovf_next;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    Done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: 7-digit default instance plus a
// 6-digit instance for overflow behaviour, checked against an arithmetic model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start7, start6;
    logic [19:0] bin7, bin6;
    logic        busy7, done7, ovf7;
    logic        busy6, done6, ovf6;
    logic [27:0] bcd7;
    logic [23:0] bcd6;

    int checks;
    int fails;
    int cyc;
    int done_cnt7;

    bin_to_bcd_seq #(.BIN_WIDTH(20), .DIGITS(7)) dut7 (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Start    (start7),
        .Bin      (bin7),
        .Busy     (busy7),
        .Done     (done7),
        .BCD      (bcd7),
        .Overflow (ovf7)
    );

    bin_to_bcd_seq #(.BIN_WIDTH(20), .DIGITS(6)) dut6 (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .Start    (start6),
        .Bin      (bin6),
        .Busy     (busy6),
        .Done     (done6),
        .BCD      (bcd6),
        .Overflow (ovf6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done7 === 1'b1) done_cnt7 <= done_cnt7 + 1;

    // Decimal digits of v, packed one per nibble, units in the low nibble
    function automatic logic [27:0] ref_bcd(input int unsigned v, input int digits);
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // One conversion on the selected instance; returns the cycle Done was seen
    task automatic conv(input bit six, input logic [19:0] b, input string tag,
                        output int t_done);
        logic [27:0] prev, exp_bcd, got;
        logic        exp_ovf;
        int          n;
        bit          seen;
        prev    = six ? {4'h0, bcd6} : bcd7;
        exp_bcd = ref_bcd(int'(b), six ? 6 : 7);
        exp_ovf = six ? (int'(b) >= 1000000) : (int'(b) >= 10000000);
        if (six) begin start6 = 1'b1; bin6 = b; end
        else begin start7 = 1'b1; bin7 = b; end
        @(posedge clk); #1;
        start6 = 1'b0; start7 = 1'b0;
        bin6 = 20'($urandom); bin7 = 20'($urandom);
        n = 1; seen = 0;
        while (!seen && n <= 40) begin
            if ((six ? done6 : done7) === 1'b1) begin
                seen = 1;
            end else begin
                got = six ? {4'h0, bcd6} : bcd7;
                checks++;
                if ((six ? busy6 : busy7) !== 1'b1 || got !== prev) begin
                    fails++;
                    $display("FAIL %s busy/hold cycle %0d: busy=%b bcd=%h, want busy=1 bcd=%h",
                             tag, n, six ? busy6 : busy7, got, prev);
                end
                @(posedge clk); #1;
                n++;
            end
        end
        t_done = cyc;
        checks++;
        if (!seen || n != 21) begin
            fails++;
            $display("FAIL %s latency: done seen=%0d at cycle %0d, want cycle 21", tag, seen, n);
        end
        got = six ? {4'h0, bcd6} : bcd7;
        checks++;
        if (got !== exp_bcd || (six ? ovf6 : ovf7) !== exp_ovf) begin
            fails++;
            $display("FAIL %s result: bcd=%h ovf=%b, want bcd=%h ovf=%b",
                     tag, got, six ? ovf6 : ovf7, exp_bcd, exp_ovf);
        end
        checks++;
        if ((six ? busy6 : busy7) !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_with_done: busy=%b, want 0", tag, six ? busy6 : busy7);
        end
        @(posedge clk); #1;
        got = six ? {4'h0, bcd6} : bcd7;
        checks++;
        if ((six ? done6 : done7) !== 1'b0 || (six ? busy6 : busy7) !== 1'b0 || got !== exp_bcd) begin
            fails++;
            $display("FAIL %s after_done: done=%b busy=%b bcd=%h, want done=0 busy=0 bcd=%h",
                     tag, six ? done6 : done7, six ? busy6 : busy7, got, exp_bcd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bcd7 !== 28'h0 || ovf7 !== 1'b0 || busy7 !== 1'b0 || done7 !== 1'b0) begin
            fails++;
            $display("FAIL reset7: bcd=%h ovf=%b busy=%b done=%b, want all 0",
                     bcd7, ovf7, busy7, done7);
        end
        checks++;
        if (bcd6 !== 24'h0 || ovf6 !== 1'b0 || busy6 !== 1'b0 || done6 !== 1'b0) begin
            fails++;
            $display("FAIL reset6: bcd=%h ovf=%b busy=%b done=%b, want all 0",
                     bcd6, ovf6, busy6, done6);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_values();
        int t;
        conv(0, 20'd0, "zero", t);
        conv(0, 20'd1048575, "max", t);
        conv(0, 20'd9, "nine", t);
        conv(0, 20'd10, "ten", t);
        for (int i = 0; i < 8; i++) begin
            conv(0, 20'($urandom), "random7", t);
        end
    endtask

    task automatic test_overflow();
        int t;
        conv(1, 20'd1000123, "ovf6", t);
        conv(1, 20'd999999, "max6", t);
        for (int i = 0; i < 6; i++) begin
            conv(1, 20'($urandom_range(1048575, 900000)), "random6", t);
        end
    endtask

    task automatic test_start_while_busy();
        int base;
        int n;
        base = done_cnt7;
        start7 = 1'b1; bin7 = 20'd12345;
        @(posedge clk); #1;
        start7 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start7 = 1'b1; bin7 = 20'd777;
        @(posedge clk); #1;
        start7 = 1'b0;
        n = 0;
        while (done7 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bcd7 !== 28'h0012345 || done7 !== 1'b1) begin
            fails++;
            $display("FAIL busy_start value: done=%b bcd=%h, want done=1 bcd=0012345",
                     done7, bcd7);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_cnt7 - base != 1) begin
            fails++;
            $display("FAIL busy_start done_count: %0d pulses, want 1", done_cnt7 - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        int t;
        base = done_cnt7;
        start7 = 1'b1; bin7 = 20'd999;
        @(posedge clk); #1;
        start7 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (busy7 !== 1'b0 || bcd7 !== 28'h0 || done7 !== 1'b0 || ovf7 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b bcd=%h done=%b ovf=%b, want all 0",
                     busy7, bcd7, done7, ovf7);
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (done_cnt7 != base) begin
            fails++;
            $display("FAIL reset_mid done_count: %0d pulses, want 0", done_cnt7 - base);
        end
        conv(0, 20'd42, "after_reset", t);
    endtask

    task automatic test_back_to_back();
        int t1, t2, t3, base;
        base = done_cnt7;
        conv(0, 20'd100, "b2b_100", t1);
        conv(0, 20'd200, "b2b_200", t2);
        conv(0, 20'd300, "b2b_300", t3);
        checks++;
        if (t2 - t1 != 22 || t3 - t2 != 22) begin
            fails++;
            $display("FAIL b2b spacing: %0d and %0d cycles, want 22 and 22", t2 - t1, t3 - t2);
        end
        @(posedge clk); #1;
        checks++;
        if (done_cnt7 - base != 3) begin
            fails++;
            $display("FAIL b2b done_count: %0d pulses, want 3", done_cnt7 - base);
        end
    endtask

    initial begin
        checks = 0; fails = 0; cyc = 0; done_cnt7 = 0;
        rst_n = 1'b0;
        start7 = 1'b0; start6 = 1'b0;
        bin7 = '0; bin6 = '0;
        test_reset();
        test_values();
        test_overflow();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
